flasher_sequencer: RTL and testbench
====================================

Name: flasher_sequencer

Overview:
- Sequential core of the bound flasher: holds the main state register and the 5-bit up/down LED counter.
- Synchronises the asynchronous flick input, generates the kickback condition and paces all advances with a programmable tick prescaler.
- Drives the 16 registered LED outputs as a thermometer code of the counter.
- Sits between the board pins (flick, LEDs) and the flasher's combinational next-state/count-control logic, which it implements internally.

Parameters:
- TICK_DIV, 1, clock cycles per sequencer step (1 = advance every cycle); legal range 1..2^24.
- SYNC_STAGES, 2, flip-flop depth of the flick synchroniser; legal range 2..4.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- flick_in  input  1  asynchronous flick button, active-high
- led  output  16  LED drive; led[i]=1 iff i < counter
- state_o  output  3  current main state
- counter_o  output  5  current counter value
- busy  output  1  high whenever state_o != INIT

Behaviour:
- Reset (rst=1 at a clk edge) has priority over everything:
  - state=INIT, counter=0, led=0, busy=0.
  - Prescaler count=0; all synchroniser flops=0.
  - Reset mid-sequence aborts immediately; no partial step completes.
- State encoding: INIT=0, ONLED0_15=1, OFFLED15_5=2, ONLED5_10=3, OFFLED10_0=4, ONLED0_5=5, OFFLED5_0=6. Code 7 is illegal.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps; tick=1 on the cycle the count equals TICK_DIV-1.
  - TICK_DIV=1 gives tick=1 every cycle.
  - The prescaler runs freely in all states.
  - State, counter and led change only on tick cycles.
- Synchroniser: flick_in passes through SYNC_STAGES flops; flick_s is the last stage. No edge detection: level-sensitive.
- kickback_match = flick_s AND (state is OFFLED15_5 or OFFLED10_0) AND (counter==5 or counter==0).
- Next state, evaluated on a tick:
  - INIT: flick_s -> ONLED0_15.
  - ONLED0_15: counter==16 -> OFFLED15_5.
  - OFFLED15_5: kickback_match -> load 16, stay. Otherwise counter==5 -> ONLED5_10.
  - ONLED5_10: counter==11 -> OFFLED10_0.
  - OFFLED10_0: kickback_match -> load 11, stay. Otherwise counter==0 -> ONLED0_5.
  - ONLED0_5: counter==6 -> OFFLED5_0.
  - OFFLED5_0: counter==0 -> INIT, load 0.
  - Illegal code 7: -> INIT on the next tick, counter held.
  - Kickback has priority over the exit transition.
- Counter update on a tick, using the count mode decoded from the NEXT state:
  - INIT: hold.
  - ON states: +1.
  - OFF states: -1.
  - A load overrides counting.
  - Decrement saturates at 0 and increment saturates at 31 (both are defensive only).
- Consequence: ON->OFF transition cycle shows 16->15, 11->10, 6->5. OFF->ON transition shows 5->6 and 0->1.
- led is registered as therm(counter_next) on the same edge as counter, so led always matches counter_o.
- busy and state_o are direct register outputs; there is no combinational path from flick_in to any output.
- Latency, TICK_DIV=1, SYNC_STAGES=2: flick_in rising before edge k gives flick_s high after edge k+1. state_o=1, counter=1 and led=0x0001 appear after edge k+2.
- A full uninterrupted run takes 57 ticks from the start tick to INIT, with counter peaks 16, 5, 11, 0, 6, 0.
- Flick held continuously: the block restarts from INIT on the tick after returning to INIT.

Test Plan:
- Reset, then idle 20 cycles with flick low -> state 0, counter 0, led 0x0000, busy 0 throughout.
- TICK_DIV=1, one flick pulse of 3 cycles -> state order 1,2,3,4,5,6,0. Counter goes 16, 15..5, 6..11, 10..0, 1..6, 5..0. led=0xFFFF at peak. INIT reached 57 ticks after the start tick; busy low afterwards.
- flick held high when counter=5 in OFFLED15_5 -> counter reloads 16, state stays 2, led 0xFFFF. Release flick -> descends 15..5, then state 3.
- flick high at counter=0 in OFFLED10_0 -> counter 11, state 4, led 0x07FF. Repeat at counter=5 in the same state -> reload 11 again.
- TICK_DIV=4 -> counter changes exactly every 4th cycle. A flick pulse of 3 cycles between ticks is lost if it drops before a tick samples flick_s; the state stays INIT.
- rst asserted at counter=9 in ONLED5_10 -> next edge gives state 0, counter 0, led 0, busy 0. A new flick restarts from counter 1.

Source files
------------

// File: rtl/flasher_sequencer.sv
// Bound-flasher sequencer: flick synchroniser, tick prescaler, main FSM and 5-bit LED counter.
// Latency: flick_in to first LED is SYNC_STAGES+1 edges when TICK_DIV=1; later steps land on prescaler ticks.
// Backpressure: none. flick_in is level-sampled on ticks, so a pulse that is gone before a tick is ignored.
module flasher_sequencer #(
  parameter int unsigned TICK_DIV    = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flick_in,
  output logic [15:0] led,
  output logic [2:0]  state_o,
  output logic [4:0]  counter_o,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_INIT      = 3'd0,
    S_ON0_15    = 3'd1,
    S_OFF15_5   = 3'd2,
    S_ON5_10    = 3'd3,
    S_OFF10_0   = 3'd4,
    S_ON0_5     = 3'd5,
    S_OFF5_0    = 3'd6
  } state_t;

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]          presc_q, presc_d;
  logic                   tick;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   flick_s;
  logic                   kick;
  state_t                 state_q, state_d;
  logic [4:0]             counter_q, counter_d;
  logic                   load;
  logic [4:0]             load_val;
  logic [15:0]            led_q, led_d;
  logic                   busy_q;

  assign flick_s = sync_q[SYNC_STAGES-1];

  // Free-running prescaler; tick fires on the last count of each period.
  always_comb begin
    tick    = (presc_q == TICK_LAST);
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // Kickback only in the two long descents, at their two reload points.
  always_comb begin
    kick = flick_s && ((state_q == S_OFF15_5) || (state_q == S_OFF10_0)) &&
           ((counter_q == 5'd5) || (counter_q == 5'd0));
  end

  // Next-state and load decisions, evaluated only on tick cycles.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = 5'd0;
    if (tick) begin
      case (state_q)
        S_INIT:    if (flick_s) state_d = S_ON0_15;
        S_ON0_15:  if (counter_q == 5'd16) state_d = S_OFF15_5;
        S_OFF15_5: begin
          if (kick) begin
            load     = 1'b1;
            load_val = 5'd16;
          end else if (counter_q == 5'd5) begin
            state_d = S_ON5_10;
          end
        end
        S_ON5_10:  if (counter_q == 5'd11) state_d = S_OFF10_0;
        S_OFF10_0: begin
          if (kick) begin
            load     = 1'b1;
            load_val = 5'd11;
          end else if (counter_q == 5'd0) begin
            state_d = S_ON0_5;
          end
        end
        S_ON0_5:   if (counter_q == 5'd6) state_d = S_OFF5_0;
        S_OFF5_0: begin
          if (counter_q == 5'd0) begin
            state_d  = S_INIT;
            load     = 1'b1;
            load_val = 5'd0;
          end
        end
        default:   state_d = S_INIT;
      endcase
    end
  end

  // Counter direction follows the state being entered, so transition ticks already count the new way.
  always_comb begin
    counter_d = counter_q;
    if (tick) begin
      if (load) begin
        counter_d = load_val;
      end else begin
        case (state_d)
          S_ON0_15, S_ON5_10, S_ON0_5: begin
            if (counter_q != 5'd31) counter_d = counter_q + 5'd1;
          end
          S_OFF15_5, S_OFF10_0, S_OFF5_0: begin
            if (counter_q != 5'd0) counter_d = counter_q - 5'd1;
          end
          default: counter_d = counter_q;
        endcase
      end
    end
  end

  // Thermometer code of the next counter value, registered alongside the counter.
  always_comb begin
    led_d = '0;
    for (int i = 0; i < 16; i++) begin
      led_d[i] = (i < int'(counter_d));
    end
  end

  // All state registers; reset wins over any step in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      sync_q    <= '0;
      state_q   <= S_INIT;
      counter_q <= 5'd0;
      led_q     <= 16'h0000;
      busy_q    <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], flick_in};
      state_q   <= state_d;
      counter_q <= counter_d;
      led_q     <= led_d;
      busy_q    <= (state_d != S_INIT);
    end
  end

  assign led       = led_q;
  assign state_o   = state_q;
  assign counter_o = counter_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_flasher_sequencer.sv
// Bench for flasher_sequencer: two instances (TICK_DIV=1 and TICK_DIV=4) compared every cycle against a phase-table model.
// Latency: checks sampled on the falling edge after each rising edge.
// Backpressure: none; stimulus driven on falling edges.
module tb_flasher_sequencer;
  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst1, flick1, rst4, flick4;
  logic [15:0] led1, led4;
  logic [2:0]  st1, st4;
  logic [4:0]  cnt1, cnt4;
  logic        busy1, busy4;

  always #5 clk = ~clk;

  flasher_sequencer #(.TICK_DIV(1), .SYNC_STAGES(SYNC)) dut1 (
    .clk(clk), .rst(rst1), .flick_in(flick1), .led(led1),
    .state_o(st1), .counter_o(cnt1), .busy(busy1));

  flasher_sequencer #(.TICK_DIV(4), .SYNC_STAGES(SYNC)) dut4 (
    .clk(clk), .rst(rst4), .flick_in(flick4), .led(led4),
    .state_o(st4), .counter_o(cnt4), .busy(busy4));

  int n_checks = 0;
  int n_fail   = 0;

  // Model: phase 0 = idle, 1..6 = sequence legs; odd legs count up, even legs count down.
  int m_p[2];
  int m_c[2];
  int m_n[2];
  bit hist[2][SYNC];
  int exit_at[7] = '{0, 16, 5, 11, 0, 6, 0};
  int reload[7]  = '{0, 0, 16, 0, 11, 0, 0};

  function automatic logic [15:0] therm(int c);
    logic [16:0] t;
    if (c >= 16) return 16'hFFFF;
    t = (17'd1 << c) - 17'd1;
    return t[15:0];
  endfunction

  function automatic void advance(int d, bit fs);
    int p = m_p[d];
    int c = m_c[d];
    if (p == 0) begin
      if (fs) begin
        m_p[d] = 1;
        m_c[d] = 1;
      end
    end else if (reload[p] != 0 && fs && (c == 5 || c == 0)) begin
      m_c[d] = reload[p];
    end else if (c == exit_at[p]) begin
      if (p == 6) begin
        m_p[d] = 0;
        m_c[d] = 0;
      end else begin
        m_p[d] = p + 1;
        m_c[d] = c + (((p + 1) % 2 == 1) ? 1 : -1);
      end
    end else begin
      m_c[d] = c + ((p % 2 == 1) ? 1 : -1);
    end
  endfunction

  function automatic void model_step(int d, logic r, logic f);
    int div = (d == 0) ? 1 : 4;
    bit fs, tk;
    if (r) begin
      m_p[d] = 0;
      m_c[d] = 0;
      m_n[d] = 0;
      for (int i = 0; i < SYNC; i++) hist[d][i] = 1'b0;
      return;
    end
    fs = hist[d][SYNC-1];
    tk = (m_n[d] == div - 1);
    m_n[d] = (m_n[d] + 1) % div;
    if (tk) advance(d, fs);
    for (int i = SYNC - 1; i > 0; i--) hist[d][i] = hist[d][i-1];
    hist[d][0] = f;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0, rst1, flick1);
    model_step(1, rst4, flick4);
    @(negedge clk);
    chk("dut1 model state", 32'(st1), 32'(m_p[0]));
    chk("dut1 model counter", 32'(cnt1), 32'(m_c[0]));
    chk("dut1 model led", 32'(led1), 32'(therm(m_c[0])));
    chk("dut1 model busy", 32'(busy1), 32'(m_p[0] != 0));
    chk("dut4 model state", 32'(st4), 32'(m_p[1]));
    chk("dut4 model counter", 32'(cnt4), 32'(m_c[1]));
    chk("dut4 model led", 32'(led4), 32'(therm(m_c[1])));
    chk("dut4 model busy", 32'(busy4), 32'(m_p[1] != 0));
  endtask

  task automatic wait_model(input int d, input int p, input int c, input int budget);
    int k = 0;
    while (!(m_p[d] == p && m_c[d] == c) && k < budget) begin
      cycle();
      k++;
    end
    n_checks++;
    if (!(m_p[d] == p && m_c[d] == c)) begin
      n_fail++;
      $display("FAIL wait dut%0d state %0d counter %0d: timed out after %0d cycles", d, p, c, budget);
    end
  endtask

  task automatic chk1(input string nm, input int s, input int c, input logic [15:0] l, input logic b);
    chk({nm, " state"}, 32'(st1), 32'(s));
    chk({nm, " counter"}, 32'(cnt1), 32'(c));
    chk({nm, " led"}, 32'(led1), 32'(l));
    chk({nm, " busy"}, 32'(busy1), 32'(b));
  endtask

  typedef struct {
    logic        rst;
    logic        flick;
    int          cyc;
    int          st;
    int          cnt;
    logic [15:0] led;
    logic        busy;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int changes, since, prev;

    // Full uninterrupted run at TICK_DIV=1 after a 3-cycle flick pulse.
    tbl[0]  = '{1'b1, 1'b0,  2, 0,  0, 16'h0000, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 20, 0,  0, 16'h0000, 1'b0};
    tbl[2]  = '{1'b0, 1'b1,  1, 0,  0, 16'h0000, 1'b0};
    tbl[3]  = '{1'b0, 1'b1,  1, 0,  0, 16'h0000, 1'b0};
    tbl[4]  = '{1'b0, 1'b1,  1, 1,  1, 16'h0001, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 15, 1, 16, 16'hFFFF, 1'b1};
    tbl[6]  = '{1'b0, 1'b0,  1, 2, 15, 16'h7FFF, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 10, 2,  5, 16'h001F, 1'b1};
    tbl[8]  = '{1'b0, 1'b0,  1, 3,  6, 16'h003F, 1'b1};
    tbl[9]  = '{1'b0, 1'b0,  5, 3, 11, 16'h07FF, 1'b1};
    tbl[10] = '{1'b0, 1'b0,  1, 4, 10, 16'h03FF, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 10, 4,  0, 16'h0000, 1'b1};
    tbl[12] = '{1'b0, 1'b0,  1, 5,  1, 16'h0001, 1'b1};
    tbl[13] = '{1'b0, 1'b0,  5, 5,  6, 16'h003F, 1'b1};
    tbl[14] = '{1'b0, 1'b0,  1, 6,  5, 16'h001F, 1'b1};
    tbl[15] = '{1'b0, 1'b0,  5, 6,  0, 16'h0000, 1'b1};
    tbl[16] = '{1'b0, 1'b0,  1, 0,  0, 16'h0000, 1'b0};
    tbl[17] = '{1'b0, 1'b0,  5, 0,  0, 16'h0000, 1'b0};

    rst1 = 1'b1; flick1 = 1'b0; rst4 = 1'b1; flick4 = 1'b0;
    for (int i = 0; i < 18; i++) begin
      rst1   = tbl[i].rst;
      rst4   = tbl[i].rst;
      flick1 = tbl[i].flick;
      repeat (tbl[i].cyc) cycle();
      chk1($sformatf("vec%0d", i), tbl[i].st, tbl[i].cnt, tbl[i].led, tbl[i].busy);
    end

    // Kickback in OFFLED15_5 at counter 5, then release.
    flick1 = 1'b1; cycle(); flick1 = 1'b0;
    wait_model(0, 2, 7, 100);
    flick1 = 1'b1;
    repeat (3) cycle();
    chk1("kick15_5 reload", 2, 16, 16'hFFFF, 1'b1);
    flick1 = 1'b0;
    cycle();
    chk1("kick15_5 descend", 2, 15, 16'h7FFF, 1'b1);
    repeat (10) cycle();
    chk1("kick15_5 bottom", 2, 5, 16'h001F, 1'b1);
    cycle();
    chk1("kick15_5 exit", 3, 6, 16'h003F, 1'b1);

    // Kickback in OFFLED10_0 at counter 0, then again at counter 5 while held.
    wait_model(0, 4, 2, 100);
    flick1 = 1'b1;
    repeat (3) cycle();
    chk1("kick10_0 at 0", 4, 11, 16'h07FF, 1'b1);
    repeat (7) cycle();
    chk1("kick10_0 at 5", 4, 11, 16'h07FF, 1'b1);
    flick1 = 1'b0;
    wait_model(0, 0, 0, 100);
    chk("kick10_0 idle busy", 32'(busy1), 32'(0));

    // Reset in the middle of ONLED5_10, then a fresh start.
    flick1 = 1'b1; cycle(); flick1 = 1'b0;
    wait_model(0, 3, 9, 100);
    rst1 = 1'b1; cycle(); rst1 = 1'b0;
    chk1("midreset", 0, 0, 16'h0000, 1'b0);
    flick1 = 1'b1; cycle(); flick1 = 1'b0;
    repeat (2) cycle();
    chk1("restart", 1, 1, 16'h0001, 1'b1);
    wait_model(0, 0, 0, 200);

    // TICK_DIV=4: counter changes exactly every 4th cycle.
    flick4 = 1'b1;
    wait_model(1, 1, 1, 20);
    flick4 = 1'b0;
    changes = 0; since = 0; prev = int'(cnt4);
    for (int i = 0; i < 16; i++) begin
      cycle();
      since++;
      if (int'(cnt4) != prev) begin
        changes++;
        chk("div4 spacing", 32'(since), 32'(4));
        since = 0;
        prev = int'(cnt4);
      end
    end
    chk("div4 change count", 32'(changes), 32'(4));
    wait_model(1, 0, 0, 400);

    // TICK_DIV=4: a 3-cycle pulse whose synchronised copy falls between ticks is lost.
    begin
      int k = 0;
      while (m_n[1] != 2 && k < 8) begin cycle(); k++; end
    end
    flick4 = 1'b1;
    repeat (3) cycle();
    flick4 = 1'b0;
    repeat (10) cycle();
    chk("div4 lost pulse state", 32'(st4), 32'(0));
    chk("div4 lost pulse busy", 32'(busy4), 32'(0));

    // Randomised bursts of flick and occasional resets on both instances.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) flick1 = ~flick1;
      if ($urandom_range(0, 9) == 0) flick4 = ~flick4;
      rst1 = ($urandom_range(0, 599) == 0);
      rst4 = ($urandom_range(0, 599) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
